// File: rtl/block_stream_reader_pkg.sv
// Shared AXI constants, FSM state encoding and a small AXI sizing helper
// for the tiled frame reader.
package block_stream_reader_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // AXI ARSIZE encoding for a beat of the given byte count
    function automatic logic [2:0] axi_size(input int unsigned bytes);
        axi_size = 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/block_stream_reader_fifo.sv
// Synchronous read-data FIFO. The head word is read straight from the
// storage array, so a word written on one edge is visible the next cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             push;
    logic             pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign pop     = rd_en && !empty;
    assign push    = wr_en && (!full || pop);
    assign rd_data = mem_q[rptr_q];
    assign count   = count_q;

    // Storage array; payload needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Upstream credit accounting guarantees a write never meets a full FIFO
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && full && !pop));

endmodule

// File: rtl/block_stream_reader.sv
// AXI4 read master that walks a row-major frame tile by tile, one INCR
// burst per tile row, and emits a tagged valid/ready pixel stream.
module block_stream_reader
    import block_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [15:0]           frame_width,
    input  logic [15:0]           frame_height,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_sof,
    output logic                  pix_eof,
    output logic                  pix_sob,
    output logic                  pix_eob,
    output logic [31:0]           blocks_per_frame,
    output logic                  busy,
    output logic                  done,
    output logic                  rresp_err
);
    localparam int BPW  = DATA_WIDTH / 8;
    localparam int LB   = $clog2(BLOCK_SIZE);
    localparam int LBPW = $clog2(BPW);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LB-1:0]         R_LAST    = LB'(BLOCK_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] TILE_STEP = ADDR_WIDTH'(BLOCK_SIZE * BPW);
    localparam logic [31:0]           CRED_LIM  = 32'(FIFO_DEPTH - BLOCK_SIZE);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, tile_addr_q, trow_addr_q, row_stride_q;
    logic [ADDR_WIDTH-1:0] tile_row_step;
    logic [15:0]           tiles_x_q, tiles_y_q, bx_q, by_q;
    logic [15:0]           tiles_x_in, tiles_y_in;
    logic [LB-1:0]         r_q, col_q, row_q, rbeat_q;
    logic [31:0]           bpf_q, blk_q, reserved;
    logic [CW-1:0]         outstanding_q, outstanding_d, fifo_count;
    logic                  rresp_err_q, eof_seen_q;
    logic                  start_acc, zero_in, ar_hs, last_burst;
    logic                  credit_now, credit_post, pix_hs, eob_w, eof_w;
    logic                  fifo_empty, drain_ok;

    assign tiles_x_in    = frame_width  >> LB;
    assign tiles_y_in    = frame_height >> LB;
    assign zero_in       = (tiles_x_in == 16'd0) || (tiles_y_in == 16'd0);
    assign start_acc     = start && (state_q == S_IDLE);
    assign ar_hs         = arvalid && arready;
    assign tile_row_step = row_stride_q << LB;
    assign last_burst    = (r_q == R_LAST) && (bx_q == tiles_x_q - 16'd1)
                           && (by_q == tiles_y_q - 16'd1);
    assign reserved      = 32'(fifo_count) + 32'(outstanding_q);
    assign credit_now    = reserved <= CRED_LIM;
    assign credit_post   = (reserved + 32'(BLOCK_SIZE)) <= CRED_LIM;
    assign pix_hs        = pix_valid && pix_ready;
    assign eob_w         = (col_q == R_LAST) && (row_q == R_LAST);
    assign eof_w         = eob_w && (blk_q == bpf_q - 32'd1);
    assign drain_ok      = fifo_empty && (outstanding_q == '0) && eof_seen_q;

    assign arlen            = 8'(BLOCK_SIZE - 1);
    assign arsize           = axi_size(BPW);
    assign arburst          = AXI_BURST_INCR;
    assign araddr           = araddr_q;
    assign rready           = !rst;
    assign blocks_per_frame = bpf_q;
    assign rresp_err        = rresp_err_q;
    assign pix_valid        = !fifo_empty;
    assign pix_sob          = pix_valid && (col_q == '0) && (row_q == '0);
    assign pix_eob          = pix_valid && eob_w;
    assign pix_sof          = pix_sob && (blk_q == 32'd0);
    assign pix_eof          = pix_valid && eof_w;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rvalid && rready),
        .wr_data (rdata),
        .rd_en   (pix_ready),
        .rd_data (pix_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: issue bursts while credit allows, then drain to EOF
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)      state_d = zero_in ? S_DRAIN : S_REQ;
            S_REQ:   if (arready)    state_d = last_burst ? S_DRAIN
                                             : (credit_post ? S_REQ : S_WAIT);
            S_WAIT:  if (credit_now) state_d = S_REQ;
            S_DRAIN: if (drain_ok)   state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        arvalid = (state_q == S_REQ);
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DRAIN) && drain_ok;
    end

    // Frame geometry latch and incremental burst address walk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            araddr_q     <= '0;
            tile_addr_q  <= '0;
            trow_addr_q  <= '0;
            row_stride_q <= '0;
            tiles_x_q    <= '0;
            tiles_y_q    <= '0;
            bx_q         <= '0;
            by_q         <= '0;
            r_q          <= '0;
            bpf_q        <= '0;
        end else if (start_acc) begin
            araddr_q     <= base_addr;
            tile_addr_q  <= base_addr;
            trow_addr_q  <= base_addr;
            row_stride_q <= ADDR_WIDTH'(tiles_x_in) << (LB + LBPW);
            tiles_x_q    <= tiles_x_in;
            tiles_y_q    <= tiles_y_in;
            bx_q         <= '0;
            by_q         <= '0;
            r_q          <= '0;
            bpf_q        <= 32'(tiles_x_in) * 32'(tiles_y_in);
        end else if (ar_hs) begin
            if (r_q != R_LAST) begin
                r_q      <= r_q + LB'(1);
                araddr_q <= araddr_q + row_stride_q;
            end else begin
                r_q <= '0;
                if (bx_q != tiles_x_q - 16'd1) begin
                    bx_q        <= bx_q + 16'd1;
                    tile_addr_q <= tile_addr_q + TILE_STEP;
                    araddr_q    <= tile_addr_q + TILE_STEP;
                end else begin
                    bx_q        <= '0;
                    by_q        <= by_q + 16'd1;
                    trow_addr_q <= trow_addr_q + tile_row_step;
                    tile_addr_q <= trow_addr_q + tile_row_step;
                    araddr_q    <= trow_addr_q + tile_row_step;
                end
            end
        end
    end

    // Outstanding beats: +BLOCK_SIZE per accepted AR, -1 per returned beat
    always_comb begin
        outstanding_d = outstanding_q;
        if (ar_hs) outstanding_d = outstanding_d + CW'(BLOCK_SIZE);
        if (rvalid && (outstanding_q != '0)) outstanding_d = outstanding_d - CW'(1);
    end

    // Read-side bookkeeping: credit, error flag, burst beat position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
            rresp_err_q   <= 1'b0;
            rbeat_q       <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (rvalid) rbeat_q <= rbeat_q + LB'(1);
            if (start_acc)                           rresp_err_q <= 1'b0;
            else if (rvalid && rresp != AXI_RESP_OKAY) rresp_err_q <= 1'b1;
        end
    end

    // Output-side tile counters that generate the stream tags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            blk_q      <= '0;
            eof_seen_q <= 1'b0;
        end else if (start_acc) begin
            col_q      <= '0;
            row_q      <= '0;
            blk_q      <= '0;
            eof_seen_q <= zero_in;
        end else if (pix_hs) begin
            col_q <= col_q + LB'(1);
            if (col_q == R_LAST) begin
                row_q <= row_q + LB'(1);
                if (row_q == R_LAST) blk_q <= blk_q + 32'd1;
            end
            if (eof_w) eof_seen_q <= 1'b1;
        end
    end

    // Slave must mark exactly the last beat of each burst
    a_rlast_pos: assert property (@(posedge clk) disable iff (rst)
        rvalid |-> (rlast == (rbeat_q == R_LAST)));

endmodule

// File: tb/tb_block_stream_reader.sv
// Bench for block_stream_reader: randomized AXI slave, scoreboard built
// from frame geometry, directed scenarios for credit, stall, error, reset.
module tb_block_stream_reader;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int B  = 8;
    localparam int FD = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [15:0]   frame_width = '0, frame_height = '0;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid, arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready;
    logic [DW-1:0] pix_data;
    logic          pix_valid, pix_ready;
    logic          pix_sof, pix_eof, pix_sob, pix_eob;
    logic [31:0]   blocks_per_frame;
    logic          busy, done, rresp_err;

    block_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(B), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .frame_width(frame_width), .frame_height(frame_height),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eof(pix_eof), .pix_sob(pix_sob), .pix_eob(pix_eob),
        .blocks_per_frame(blocks_per_frame), .busy(busy), .done(done), .rresp_err(rresp_err));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    // Logs, scoreboard, slave state
    logic [31:0] ar_log[$], exp_ar[$], burst_q[$];
    logic [35:0] pix_log[$], exp_pix[$];
    int          exp_bpf;
    int          cyc = 0, done_cnt = 0, done_cyc = -1, eof_cyc = -1, start_cyc = -1;
    int          stab_err = 0, ar_total = 0, bursts_done = 0, beat_idx = 0;
    int          stall_at = -1, stall_left = 0, err_burst = -1, err_beat = 0;
    int          rdy_mode = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    // AXI slave model and stream monitor: observe mid-cycle, drive after the edge
    initial begin : slave_monitor
        logic          nx_arready, nx_rvalid, nx_rlast;
        logic [1:0]    nx_rresp;
        logic [31:0]   nx_rdata;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0; pix_ready = 1;
        forever begin
            @(negedge clk);
            cyc++;
            nx_arready = 0; nx_rvalid = 0; nx_rlast = 0; nx_rresp = '0; nx_rdata = '0;
            if (rst) begin
                burst_q.delete(); beat_idx = 0; prev_stall = 0;
            end else begin
                if (prev_stall && (!arvalid || araddr !== prev_addr)) stab_err++;
                prev_stall = arvalid && !arready;
                prev_addr  = araddr;
                if (arvalid && arready) begin
                    ar_log.push_back(araddr); burst_q.push_back(araddr); ar_total++;
                end
                if (pix_valid && pix_ready) begin
                    pix_log.push_back({pix_data, pix_sof, pix_eof, pix_sob, pix_eob});
                    if (pix_eof) eof_cyc = cyc;
                end
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (start && !busy) start_cyc = cyc;
                if (rvalid && rready) begin
                    beat_idx++;
                    if (beat_idx == B) begin
                        beat_idx = 0; void'(burst_q.pop_front()); bursts_done++;
                    end
                end
                if (ar_total == stall_at && stall_left > 0) begin
                    stall_left--;
                end else begin
                    nx_arready = ($urandom_range(0, 3) != 0);
                end
                if (burst_q.size() != 0 && $urandom_range(0, 4) != 0) begin
                    nx_rvalid = 1;
                    nx_rdata  = mem_word(burst_q[0] + 32'(beat_idx * 4));
                    nx_rlast  = (beat_idx == B - 1);
                    nx_rresp  = (bursts_done == err_burst && beat_idx == err_beat) ? 2'b10 : 2'b00;
                end
            end
            @(posedge clk); #1;
            arready = nx_arready; rvalid = nx_rvalid; rdata = nx_rdata;
            rlast = nx_rlast; rresp = nx_rresp;
            pix_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Reference: list every burst address and every tagged pixel of the frame
    task automatic build_expected(input int w, input int h, input logic [31:0] base);
        int tx, ty, wf, tile;
        logic [31:0] a, pa;
        logic sob, eob;
        tx = w / B; ty = h / B; wf = tx * B;
        exp_bpf = tx * ty;
        exp_ar.delete(); exp_pix.delete();
        for (int by = 0; by < ty; by++)
            for (int bx = 0; bx < tx; bx++) begin
                tile = by * tx + bx;
                for (int r = 0; r < B; r++) begin
                    a = base + 32'(((by * B + r) * wf + bx * B) * 4);
                    exp_ar.push_back(a);
                    for (int c = 0; c < B; c++) begin
                        pa  = a + 32'(c * 4);
                        sob = (r == 0 && c == 0);
                        eob = (r == B - 1 && c == B - 1);
                        exp_pix.push_back({mem_word(pa), sob && tile == 0,
                                           eob && tile == exp_bpf - 1, sob, eob});
                    end
                end
            end
    endtask

    task automatic start_frame(input int w, input int h, input logic [31:0] base);
        build_expected(w, h, base);
        ar_log.delete(); pix_log.delete();
        done_cnt = 0; done_cyc = -1; eof_cyc = -1; start_cyc = -1; stab_err = 0;
        frame_width = 16'(w); frame_height = 16'(h); base_addr = base;
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic finish_frame(input string tag);
        int k, n, e;
        k = 0;
        while (done_cnt == 0 && k < 20000) begin @(posedge clk); #1; k++; end
        if (k >= 20000) check({tag, " done timeout"}, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, " done count"}, done_cnt, 1);
        check({tag, " busy after"}, busy, 0);
        check({tag, " blocks_per_frame"}, blocks_per_frame, exp_bpf);
        check({tag, " ar count"}, ar_log.size(), exp_ar.size());
        check({tag, " pix count"}, pix_log.size(), exp_pix.size());
        check({tag, " ar stable"}, stab_err, 0);
        if (exp_bpf == 0) check({tag, " done after start"}, done_cyc - start_cyc, 1);
        else              check({tag, " done after eof"}, done_cyc - eof_cyc, 1);
        n = (ar_log.size() < exp_ar.size()) ? ar_log.size() : exp_ar.size();
        for (int i = 0; i < n; i++) begin
            e = n_errors;
            check($sformatf("%s araddr[%0d]", tag, i), ar_log[i], exp_ar[i]);
            if (n_errors != e) break;
        end
        n = (pix_log.size() < exp_pix.size()) ? pix_log.size() : exp_pix.size();
        for (int i = 0; i < n; i++) begin
            e = n_errors;
            check($sformatf("%s pix{data,sof,eof,sob,eob}[%0d]", tag, i), pix_log[i], exp_pix[i]);
            if (n_errors != e) break;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " ctl outputs"},
              {arvalid, busy, done, pix_valid, pix_sof, pix_eof, pix_sob, pix_eob, rresp_err, rready},
              10'b0);
        check({tag, " araddr"}, araddr, 0);
        check({tag, " blocks_per_frame"}, blocks_per_frame, 0);
        check({tag, " arlen/arsize/arburst"}, {arlen, arsize, arburst}, {8'd7, 3'd2, 2'b01});
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k, w, h;
        logic [31:0] base;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 0;
        @(posedge clk); #1;
        check("rready out of reset", rready, 1);

        // 1: basic 16x16 frame, consumer always ready
        rdy_mode = 0;
        start_frame(16, 16, 32'h0);
        finish_frame("t1");

        // 2: consumer stalled from start; credit caps ARs at two
        rdy_mode = 2;
        start_frame(16, 16, 32'h0000_4000);
        repeat (80) @(posedge clk);
        #1;
        check("t2 ar count while stalled", ar_log.size(), 2);
        check("t2 arvalid while stalled", arvalid, 0);
        rdy_mode = 1;
        finish_frame("t2");

        // 3: arready held low for 20 cycles on the third AR
        rdy_mode = 0;
        stall_at = ar_total + 2; stall_left = 20;
        start_frame(16, 16, 32'h0000_8000);
        finish_frame("t3");
        check("t3 stall applied", stall_left, 0);
        stall_at = -1;

        // 4: SLVERR on one beat of the fifth burst
        err_burst = bursts_done + 4; err_beat = 3;
        start_frame(16, 16, 32'h0);
        finish_frame("t4");
        check("t4 rresp_err sticky", rresp_err, 1);
        err_burst = -1;
        start_frame(16, 16, 32'h0);
        check("t4 rresp_err cleared by start", rresp_err, 0);
        finish_frame("t4b");

        // 5: start while busy is ignored; width below one tile gives empty frame
        rdy_mode = 1;
        start_frame(16, 16, 32'h0000_0100);
        repeat (30) @(posedge clk);
        #1;
        frame_width = 16'd64; frame_height = 16'd64; base_addr = 32'h0001_0000; start = 1;
        @(posedge clk); #1;
        start = 0;
        finish_frame("t5 mid start");
        start_frame(4, 16, 32'h0);
        finish_frame("t5 zero");

        // 6: reset after 100 pixels, then a clean frame
        rdy_mode = 0;
        start_frame(16, 16, 32'h0000_2000);
        k = 0;
        while (pix_log.size() < 100 && k < 5000) begin @(posedge clk); #1; k++; end
        if (k >= 5000) check("t6 reach 100 pixels timeout", 0, 1);
        rst = 1;
        #1;
        check_reset_state("t6 mid reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(posedge clk); #1;
        start_frame(16, 16, 32'h0000_2000);
        finish_frame("t6 after reset");

        // Randomized frames
        for (int i = 0; i < 4; i++) begin
            w = $urandom_range(0, 40);
            h = $urandom_range(0, 40);
            base = $urandom & 32'h000F_FFE0;
            rdy_mode = $urandom_range(0, 1);
            start_frame(w, h, base);
            finish_frame($sformatf("rand%0d %0dx%0d", i, w, h));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
